// File: rtl/multichannel_sample_sequencer.sv
// Per-sample sequencer for N parallel audio lanes feeding two DSP pipelines.
// Input gain -> pipeline tick -> wait for both -> crossfade mix -> output gain.
`timescale 1ns/1ps
module multichannel_sample_sequencer #(
  parameter int unsigned data_width     = 16,
  parameter int unsigned n_channels     = 2,
  parameter int unsigned gain_shift     = 5,
  parameter int unsigned xfade_log2     = 6,
  parameter int unsigned timeout_cycles = 4095
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [n_channels*data_width-1:0]   in_samples,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [n_channels*data_width-1:0]   pipe_in,
  output logic                               pipe_tick,
  input  logic [n_channels*data_width-1:0]   pipe_a_out,
  input  logic [n_channels*data_width-1:0]   pipe_b_out,
  input  logic                               pipe_a_ready,
  input  logic                               pipe_b_ready,
  input  logic [data_width-1:0]              gain_data,
  input  logic                               set_input_gain,
  input  logic                               set_output_gain,
  input  logic                               swap_pipelines,
  output logic                               current_pipeline,
  output logic                               swapping,
  output logic [n_channels*data_width-1:0]   out_samples,
  output logic                               out_valid,
  output logic                               overrun,
  output logic                               timeout,
  input  logic                               err_clear,
  output logic [31:0]                        frame_count
);

  localparam int unsigned DW = data_width;
  localparam int unsigned FW = n_channels * data_width;
  localparam int unsigned R  = 1 << xfade_log2;
  localparam int unsigned TW = $clog2(timeout_cycles + 1);
  localparam int unsigned MW = DW + xfade_log2 + 2;
  localparam logic signed [2*DW-1:0] SatMax = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SatMin = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] Unity = DW'(1) << gain_shift;
  localparam logic [xfade_log2:0] PLast = (xfade_log2 + 1)'(R - 1);

  typedef enum logic [2:0] {StIdle, StGain, StTick, StWait, StMix, StOut} state_e;

  state_e state_q, state_d;
  logic [FW-1:0]     frame_q, pipe_in_q, mix_q, out_q;
  logic [FW-1:0]     gained, mixed, outg, act_frame, oth_frame;
  logic [DW-1:0]     in_gain_q, out_gain_q;
  logic [TW-1:0]     tmo_q;
  logic [xfade_log2:0] p_q;
  logic              mute_q, pending_q, swapping_q, cur_q, out_valid_q;
  logic              overrun_q, timeout_q;
  logic [31:0]       frame_count_q;
  logic              wait_done, wait_expired;

  function automatic logic [DW-1:0] apply_gain(input logic signed [DW-1:0] x,
                                               input logic signed [DW-1:0] g);
    logic signed [2*DW-1:0] prod, shf;
    logic [DW-1:0] res;
    prod = x * g;
    shf  = prod >>> gain_shift;
    res  = shf[DW-1:0];
    if (shf > SatMax)      res = {1'b0, {(DW-1){1'b1}}};
    else if (shf < SatMin) res = {1'b1, {(DW-1){1'b0}}};
    return res;
  endfunction

  // Weights sum to R, so the widened sum cannot overflow before the shift.
  function automatic logic [DW-1:0] mix_lane(input logic signed [DW-1:0] act,
                                             input logic signed [DW-1:0] oth,
                                             input logic [xfade_log2:0] p);
    logic signed [MW-1:0] ae, oe, wa, wo, sum;
    ae  = MW'(act);
    oe  = MW'(oth);
    wa  = MW'(R) - MW'(p);
    wo  = MW'(p);
    sum = (ae * wa + oe * wo) >>> xfade_log2;
    return sum[DW-1:0];
  endfunction

  // First WAIT cycle (tmo_q == 0) ignores the ready inputs.
  assign wait_done    = (state_q == StWait) && (tmo_q != '0) && pipe_a_ready && pipe_b_ready;
  assign wait_expired = (state_q == StWait) && !wait_done && (tmo_q == TW'(timeout_cycles));
  assign act_frame    = cur_q ? pipe_b_out : pipe_a_out;
  assign oth_frame    = cur_q ? pipe_a_out : pipe_b_out;

  always_comb begin
    gained = '0;
    mixed  = '0;
    outg   = '0;
    for (int i = 0; i < int'(n_channels); i++) begin
      gained[i*DW +: DW] = apply_gain(frame_q[i*DW +: DW], in_gain_q);
      mixed[i*DW +: DW]  = mute_q ? '0 : mix_lane(act_frame[i*DW +: DW],
                                                   oth_frame[i*DW +: DW], p_q);
      outg[i*DW +: DW]   = apply_gain(mix_q[i*DW +: DW], out_gain_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StGain;
      StGain:  state_d = StTick;
      StTick:  state_d = StWait;
      StWait:  if (wait_done || wait_expired) state_d = StMix;
      StMix:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    pipe_tick = (state_q == StTick);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q       <= '0;
      pipe_in_q     <= '0;
      mix_q         <= '0;
      out_q         <= '0;
      in_gain_q     <= Unity;
      out_gain_q    <= Unity;
      tmo_q         <= '0;
      p_q           <= '0;
      mute_q        <= 1'b0;
      pending_q     <= 1'b0;
      swapping_q    <= 1'b0;
      cur_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (set_input_gain)  in_gain_q  <= gain_data;
      if (set_output_gain) out_gain_q <= gain_data;

      if (err_clear)                            overrun_q <= 1'b0;
      else if (in_valid && state_q != StIdle)   overrun_q <= 1'b1;
      if (err_clear)         timeout_q <= 1'b0;
      else if (wait_expired) timeout_q <= 1'b1;

      if (state_q == StIdle && in_valid && pending_q) begin
        pending_q  <= 1'b0;
        swapping_q <= 1'b1;
        p_q        <= '0;
      end else if (swap_pipelines && !swapping_q && !pending_q) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        StIdle: if (in_valid) frame_q <= in_samples;
        StGain: begin
          pipe_in_q <= gained;
          mute_q    <= 1'b0;
        end
        StTick: tmo_q <= '0;
        StWait: begin
          if (wait_expired)    mute_q <= 1'b1;
          else if (!wait_done) tmo_q  <= tmo_q + 1'b1;
        end
        StMix:  mix_q <= mixed;
        StOut: begin
          out_q         <= outg;
          out_valid_q   <= 1'b1;
          frame_count_q <= frame_count_q + 32'd1;
          if (swapping_q) begin
            if (p_q == PLast) begin
              cur_q      <= ~cur_q;
              swapping_q <= 1'b0;
              p_q        <= '0;
            end else begin
              p_q <= p_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pipe_in          = pipe_in_q;
  assign out_samples      = out_q;
  assign out_valid        = out_valid_q;
  assign current_pipeline = cur_q;
  assign swapping         = swapping_q;
  assign overrun          = overrun_q;
  assign timeout          = timeout_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_multichannel_sample_sequencer.sv
// Directed bench for multichannel_sample_sequencer (N=2, DW=16 defaults).
`timescale 1ns/1ps
module tb_multichannel_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_samples, pipe_in, pipe_a_out, pipe_b_out, out_samples;
  logic        in_valid, in_ready, pipe_tick, pipe_a_ready, pipe_b_ready;
  logic [15:0] gain_data;
  logic        set_input_gain, set_output_gain, swap_pipelines;
  logic        current_pipeline, swapping, out_valid, overrun, timeout, err_clear;
  logic [31:0] frame_count;

  logic        echo;
  logic [31:0] echo_q, const_a, const_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] gi;
    logic [15:0] go;
    logic [31:0] frame;
    logic [31:0] exp_pin;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  multichannel_sample_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .in_samples       (in_samples),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pipe_in          (pipe_in),
    .pipe_tick        (pipe_tick),
    .pipe_a_out       (pipe_a_out),
    .pipe_b_out       (pipe_b_out),
    .pipe_a_ready     (pipe_a_ready),
    .pipe_b_ready     (pipe_b_ready),
    .gain_data        (gain_data),
    .set_input_gain   (set_input_gain),
    .set_output_gain  (set_output_gain),
    .swap_pipelines   (swap_pipelines),
    .current_pipeline (current_pipeline),
    .swapping         (swapping),
    .out_samples      (out_samples),
    .out_valid        (out_valid),
    .overrun          (overrun),
    .timeout          (timeout),
    .err_clear        (err_clear),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: either echoes the ticked frame or outputs fixed frames.
  always @(posedge clk) if (pipe_tick) echo_q <= pipe_in;
  assign pipe_a_out = echo ? echo_q : const_a;
  assign pipe_b_out = echo ? echo_q : const_b;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic set_gains(input logic [15:0] gi, input logic [15:0] go);
    @(negedge clk);
    gain_data = gi; set_input_gain = 1'b1;
    @(negedge clk);
    set_input_gain = 1'b0; gain_data = go; set_output_gain = 1'b1;
    @(negedge clk);
    set_output_gain = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] frame, output int lat,
                           output logic [31:0] pin, output logic [31:0] outv);
    @(negedge clk);
    in_samples = frame; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; pin = 32'hxxxx_xxxx; outv = 32'hxxxx_xxxx;
    for (int c = 1; c <= 6000; c++) begin
      @(posedge clk); #1;
      if (pipe_tick) pin = pipe_in;
      if (out_valid) begin
        lat = c; outv = out_samples;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, pulses;
    logic [31:0] pin, outv;
    logic [15:0] e16;

    vecs[0] = '{16'h0020, 16'h0020, 32'hF000_1000, 32'hF000_1000, 32'hF000_1000};
    vecs[1] = '{16'h0040, 16'h0020, 32'h9000_7000, 32'h8000_7FFF, 32'h8000_7FFF};
    vecs[2] = '{16'h0010, 16'h0020, 32'hFFFF_0003, 32'hFFFF_0001, 32'hFFFF_0001};
    vecs[3] = '{16'h0020, 16'h0040, 32'hC000_2000, 32'hC000_2000, 32'h8000_4000};
    vecs[4] = '{16'hFFE0, 16'h0020, 32'h8000_1234, 32'h7FFF_EDCC, 32'h7FFF_EDCC};
    vecs[5] = '{16'h0030, 16'h0008, 32'hFF00_0100, 32'hFE80_0180, 32'hFFA0_0060};

    reset = 1'b0; in_samples = '0; in_valid = 1'b0; gain_data = '0;
    set_input_gain = 1'b0; set_output_gain = 1'b0; swap_pipelines = 1'b0;
    err_clear = 1'b0; pipe_a_ready = 1'b1; pipe_b_ready = 1'b1;
    echo = 1'b1; const_a = '0; const_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'({in_ready, out_valid, pipe_tick, overrun, timeout,
                              current_pipeline, swapping}), 32'b1000000);
    check("reset_out_samples", out_samples, 32'h0);
    check("reset_pipe_in", pipe_in, 32'h0);
    check("reset_frame_count", frame_count, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Gain vectors with echoing pipelines
    for (int v = 0; v < 6; v++) begin
      set_gains(vecs[v].gi, vecs[v].go);
      run_frame(vecs[v].frame, lat, pin, outv);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd6);
      check($sformatf("vec%0d_pipe_in", v), pin, vecs[v].exp_pin);
      check($sformatf("vec%0d_out", v), outv, vecs[v].exp_out);
      if (v == 0) check("first_frame_count", frame_count, 32'd1);
    end
    check("table_frame_count", frame_count, 32'd6);

    // Crossfade A=0x4000 -> B=0 over 64 frames
    set_gains(16'h0020, 16'h0020);
    echo = 1'b0; const_a = 32'h4000_4000; const_b = 32'h0;
    @(negedge clk);
    swap_pipelines = 1'b1;
    @(negedge clk);
    swap_pipelines = 1'b0;
    check("swap_pending_not_swapping", 32'(swapping), 32'd0);
    for (int k = 0; k < 64; k++) begin
      run_frame(32'h0, lat, pin, outv);
      e16 = 16'h4000 - 16'(k * 256);
      check($sformatf("xfade_frame%0d", k), outv, {e16, e16});
      if (k == 0) check("swapping_active", 32'(swapping), 32'd1);
    end
    check("xfade_current_pipeline", 32'(current_pipeline), 32'd1);
    check("xfade_swapping_done", 32'(swapping), 32'd0);
    run_frame(32'h0, lat, pin, outv);
    check("post_xfade_out", outv, 32'h0);
    check("post_xfade_frame_count", frame_count, 32'd71);

    // Timeout: A never ready, B active with nonzero output
    const_b = 32'h1111_2222;
    pipe_a_ready = 1'b0;
    run_frame(32'h0, lat, pin, outv);
    check("timeout_latency", 32'(lat), 32'd4100);
    check("timeout_muted_out", outv, 32'h0);
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_no_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("timeout_cleared", 32'(timeout), 32'd0);
    pipe_a_ready = 1'b1;
    run_frame(32'h0, lat, pin, outv);
    check("after_timeout_latency", 32'(lat), 32'd6);
    check("after_timeout_out", outv, 32'h1111_2222);

    // Overrun: second in_valid while waiting is dropped
    @(negedge clk);
    in_samples = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    count_pulses(20, pulses);
    check("overrun_single_out_valid", 32'(pulses), 32'd1);
    check("overrun_flag", 32'(overrun), 32'd1);
    check("overrun_frame_count", frame_count, 32'd74);

    // err_clear wins over a same-cycle overrun
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; err_clear = 1'b0;
    check("err_clear_priority", 32'(overrun), 32'd0);
    repeat (20) @(posedge clk);

    // Reset while in MIX aborts the frame
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_frame_count", frame_count, 32'd0);
    check("midreset_current_pipeline", 32'(current_pipeline), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    count_pulses(10, pulses);
    check("midreset_no_out_valid", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
